free_ptr_pool: RTL and testbench

Free-address pool for the hash-table data RAM. It is the receiving end of the empty-pointer return path driven by the delete engine (`add_empty_ptr` / `add_empty_ptr_en`), and the supplier of free data-table addresses to the insert engine. After reset it self-initialises with every data-table address. It then operates as a FIFO free list, with optional double-free detection and sticky error reporting.

---
 rtl/free_ptr_pool.sv | 205 ++++++++++++++++++++
 tb/tb_free_ptr_pool.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/free_ptr_pool.sv
// free_ptr_pool
//   Free-address pool for the hash-table data RAM. After reset it fills
//   itself with every data-table address (0..DEPTH-1, one per cycle). It then
//   works as a FIFO free list. The delete engine returns addresses to it, and
//   it hands free addresses to the insert engine in show-ahead form.
//
//   Optional feature macro: FREE_PTR_POOL_DOUBLE_FREE_CHECK_EN
//     When defined, a DEPTH-bit map of the addresses currently held is kept.
//     A push of an address that is already free is dropped and sets err_o[2].
//     When undefined, err_o[2] is tied to 0 and duplicate pushes are accepted.
//
// Ports
//   clk_i                   : clock
//   rst_i                   : synchronous reset, active low
//   add_empty_ptr_i         : address being returned to the pool
//   add_empty_ptr_en_i      : single-cycle push strobe (no backpressure)
//   next_empty_ptr_o        : head of the free list, 0 while not valid
//   next_empty_ptr_val_o    : head is valid
//   next_empty_ptr_rd_ack_i : pop the head (ignored while head is not valid)
//   init_done_o             : initial fill is complete
//   free_cnt_o              : number of free addresses held
//   err_o                   : sticky {double_free, overflow, underflow}

`ifndef TABLE_ADDR_WIDTH
`define TABLE_ADDR_WIDTH 4
`endif

module free_ptr_pool #(
  parameter int A_WIDTH = `TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic               init_done_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic [2:0]         err_o
);

  localparam int               DEPTH     = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] FULL_CNT  = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    INIT_S,
    WORK_S
  } state_t;

  state_t state;
  state_t state_next;

  // Free-list storage; contents are not reset because the fill rewrites them.
  logic [A_WIDTH-1:0] mem [DEPTH];

  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH-1:0] init_addr;
  logic [A_WIDTH:0]   cnt;
  logic [2:0]         err;

  logic [A_WIDTH-1:0] head;
  logic               val;
  logic               pop;
  logic               full;
  logic               dup;
  logic               push;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_waddr;
  logic [A_WIDTH-1:0] mem_wdata;
  logic               err_df;
  logic               err_ovf;
  logic               err_udf;

  assign head = mem[rd_ptr];
  assign full = (cnt == FULL_CNT);

  // Pop qualification is kept outside the FSM block because the duplicate
  // check below depends on it and the FSM block depends on the duplicate check.
  assign val = (state == WORK_S) && (cnt != '0);
  assign pop = val && next_empty_ptr_rd_ack_i;

`ifdef FREE_PTR_POOL_DOUBLE_FREE_CHECK_EN
  logic [DEPTH-1:0] free_map;

  // An address popped in this same cycle is no longer free, so pushing it
  // back is legal.
  assign dup = free_map[add_empty_ptr_i] && !(pop && (head == add_empty_ptr_i));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      free_map <= '0;
    end else if (state == INIT_S) begin
      free_map[init_addr] <= 1'b1;
    end else begin
      // Clear comes first so that a push of the popped address re-sets the bit.
      if (pop) begin
        free_map[head] <= 1'b0;
      end
      if (push) begin
        free_map[add_empty_ptr_i] <= 1'b1;
      end
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Next state and per-cycle controls.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr;
    mem_wdata  = add_empty_ptr_i;
    err_df     = 1'b0;
    err_ovf    = 1'b0;
    err_udf    = 1'b0;

    unique case (state)
      INIT_S: begin
        mem_we    = 1'b1;
        mem_waddr = init_addr;
        mem_wdata = init_addr;
        // Returned addresses cannot be stored during the fill.
        err_ovf   = add_empty_ptr_en_i;
        if (init_addr == LAST_ADDR) begin
          state_next = WORK_S;
        end
      end

      WORK_S: begin
        err_udf = next_empty_ptr_rd_ack_i && !val;
        if (add_empty_ptr_en_i) begin
          // Double free takes precedence over overflow.
          if (dup) begin
            err_df = 1'b1;
          end else if (full && !pop) begin
            err_ovf = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        mem_we = push;
      end

      default: begin
        state_next = INIT_S;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= INIT_S;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      init_addr <= '0;
      cnt       <= '0;
      err       <= '0;
    end else begin
      if (state == INIT_S) begin
        // After the last fill write both init_addr and wr_ptr wrap to 0.
        init_addr <= init_addr + A_WIDTH'(1);
        wr_ptr    <= wr_ptr + A_WIDTH'(1);
        cnt       <= cnt + (A_WIDTH + 1)'(1);
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + A_WIDTH'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + A_WIDTH'(1);
        end
        if (push && !pop) begin
          cnt <= cnt + (A_WIDTH + 1)'(1);
        end else if (pop && !push) begin
          cnt <= cnt - (A_WIDTH + 1)'(1);
        end
      end
      err <= err | {err_df, err_ovf, err_udf};
    end
  end

  assign next_empty_ptr_val_o = val;
  assign next_empty_ptr_o     = val ? head : '0;
  assign init_done_o          = (state == WORK_S);
  assign free_cnt_o           = cnt;
  assign err_o                = err;

endmodule

// File: tb/tb_free_ptr_pool.sv
// Testbench for free_ptr_pool (A_WIDTH = 4, DEPTH = 16).
// The reference model is a queue of free addresses plus a membership bitmap.

module tb_free_ptr_pool;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

`ifdef FREE_PTR_POOL_DOUBLE_FREE_CHECK_EN
  localparam bit DF_EN = 1'b1;
`else
  localparam bit DF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] push_addr;
  logic          push_en;
  logic [AW-1:0] head;
  logic          head_val;
  logic          ack;
  logic          init_done;
  logic [AW:0]   free_cnt;
  logic [2:0]    err;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // reference model state
  bit              m_valid = 1'b0;
  bit              m_init  = 1'b1;
  int unsigned     m_icnt  = 0;
  int unsigned     m_q[$];
  bit [DEPTH-1:0]  m_map   = '0;
  bit [2:0]        m_err   = '0;

  always #5 clk = ~clk;

  free_ptr_pool #(.A_WIDTH(AW)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .add_empty_ptr_i         (push_addr),
    .add_empty_ptr_en_i      (push_en),
    .next_empty_ptr_o        (head),
    .next_empty_ptr_val_o    (head_val),
    .next_empty_ptr_rd_ack_i (ack),
    .init_done_o             (init_done),
    .free_cnt_o              (free_cnt),
    .err_o                   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // One rising edge of the specified pool behaviour.
  task automatic model_edge(input bit r, input bit en, input int unsigned a, input bit pk);
    bit          was_full;
    bit          do_pop;
    int unsigned p;
    if (!r) begin
      m_valid = 1'b1;
      m_init  = 1'b1;
      m_icnt  = 0;
      m_q.delete();
      m_map   = '0;
      m_err   = '0;
    end else if (m_valid) begin
      if (m_init) begin
        if (en) m_err[1] = 1'b1;
        m_q.push_back(m_icnt);
        m_map[m_icnt] = 1'b1;
        m_icnt++;
        if (m_icnt == DEPTH) m_init = 1'b0;
      end else begin
        was_full = (m_q.size() == DEPTH);
        do_pop   = pk && (m_q.size() != 0);
        if (pk && m_q.size() == 0) m_err[0] = 1'b1;
        if (do_pop) begin
          p = m_q.pop_front();
          m_map[p] = 1'b0;
        end
        if (en) begin
          if (DF_EN && m_map[a]) m_err[2] = 1'b1;
          else if (was_full && !do_pop) m_err[1] = 1'b1;
          else begin
            m_q.push_back(a);
            m_map[a] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit          e_val;
    int unsigned e_head;
    e_val  = !m_init && (m_q.size() != 0);
    e_head = e_val ? m_q[0] : 0;
    check("init_done", init_done, !m_init);
    check("val", head_val, e_val);
    check("head", head, e_head);
    check("free_cnt", free_cnt, m_q.size());
    check("err", err, m_err);
  endtask

  task automatic step(input bit r, input bit en, input int unsigned a, input bit pk);
    rst       = r;
    push_en   = en;
    push_addr = a[AW-1:0];
    ack       = pk;
    @(negedge clk);
    if (m_valid) check_outputs();
    @(posedge clk);
    model_edge(r, en, a, pk);
    #1;
  endtask

  task automatic reset_and_fill();
    step(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; push_en = 1'b0; push_addr = '0; ack = 1'b0;

    // reset values
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 3, 1'b1);
    check("rst_done", init_done, 1'b0);
    check("rst_val", head_val, 1'b0);
    check("rst_cnt", free_cnt, 0);
    check("rst_err", err, 0);

    // fill with ack held, then pops 0..15 back to back
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, 1'b1);
    check("t1_done", init_done, 1'b1);
    check("t1_cnt", free_cnt, DEPTH);
    check("t1_head", head, 0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, 1'b1);
    check("t1_empty_val", head_val, 1'b0);
    check("t1_empty_cnt", free_cnt, 0);

    // pop 0,1,2 then return 1 and 0
    reset_and_fill();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b1);
    step(1'b1, 1'b1, 1, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    check("t2_cnt", free_cnt, 15);
    check("t2_head", head, 3);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 0, 1'b1);

    // simultaneous push and pop with a single entry held
    reset_and_fill();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 0, 1'b1);
    check("t3_head_before", head, 15);
    step(1'b1, 1'b1, 7, 1'b1);
    check("t3_cnt", free_cnt, 1);
    check("t3_head", head, 7);

    // push into a full pool
    reset_and_fill();
    step(1'b1, 1'b1, 5, 1'b0);
    check("t4_err", err, DF_EN ? 3'b100 : 3'b010);
    check("t4_cnt", free_cnt, DEPTH);

    // underflow, then push with ack on an empty pool
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b1);
    check("t5_udf", err[0], 1'b1);
    check("t5_cnt0", free_cnt, 0);
    step(1'b1, 1'b1, 9, 1'b1);
    check("t5_cnt1", free_cnt, 1);
    check("t5_head", head, 9);

    // reset at init edge 7
    reset_and_fill();
    step(1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    check("t6_rst_cnt", free_cnt, 0);
    check("t6_rst_done", init_done, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 0, 1'b0);
    check("t6_not_yet", init_done, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    check("t6_done", init_done, 1'b1);
    check("t6_head", head, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 399) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 99) < 55);
    end

    @(negedge clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
